// File: rtl/csr_access_unit_if.sv
// Bundles the decode request, CSR file port and writeback response of csr_access_unit.
// slave is the unit's own view; master is the surrounding pipeline and CSR file.
interface csr_access_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_csr_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic [4:0]      req_rs1_idx;
    logic            req_kill;

    logic [11:0]     csr_read_index;
    logic [XLEN-1:0] csr_data_r;
    logic [11:0]     csr_write_index;
    logic            csr_write;
    logic [XLEN-1:0] csr_data_w;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_ill;

    logic            busy;

    modport slave (
        input  req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, req_kill,
        output req_ready,
        output csr_read_index, csr_write_index, csr_write, csr_data_w,
        input  csr_data_r,
        output rsp_valid, rsp_rd_data, rsp_ill,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_funct3, req_csr_addr, req_rs1_data, req_rs1_idx, req_kill,
        input  req_ready,
        input  csr_read_index, csr_write_index, csr_write, csr_data_w,
        output csr_data_r,
        input  rsp_valid, rsp_rd_data, rsp_ill,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr initiator: IDLE -> READ -> WRITE -> RESP, one request per 4 cycles; write strobe is state-decoded.
// Define CSR_ACC_ADDR_CHECK_EN to restrict accesses to the implemented machine-mode CSR whitelist.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    csr_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] old_q;
    logic            wr_en_q;
    logic            ill_q;

    logic            req_ready_int;
    logic            accept;
    logic            addr_ok;
    logic            illegal;
    logic [XLEN-1:0] wdata;

    assign req_ready_int = (state_q == IDLE) && !bus.req_kill;
    assign accept        = bus.req_valid && req_ready_int;

`ifdef CSR_ACC_ADDR_CHECK_EN
    always_comb begin
        addr_ok = 1'b0;
        case (addr_q)
            12'h300, 12'h304, 12'h305, 12'h340,
            12'h341, 12'h342, 12'h343, 12'h344: addr_ok = 1'b1;
            default:                            addr_ok = 1'b0;
        endcase
    end
`else
    assign addr_ok = 1'b1;
`endif

    // op 00 covers both reserved funct3 encodings 000 and 100
    assign illegal = (op_q == 2'b00)
                   || (wr_en_q && (addr_q[11:10] == 2'b11))
                   || !addr_ok;

    always_comb begin
        wdata = operand_q;
        case (op_q)
            2'b10:   wdata = old_q | operand_q;
            2'b11:   wdata = old_q & ~operand_q;
            default: wdata = operand_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = READ;
            end
            READ: begin
                if (bus.req_kill)  state_d = IDLE;
                else if (illegal)  state_d = RESP;
                else               state_d = WRITE;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            wr_en_q   <= 1'b0;
            old_q     <= '0;
            ill_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= bus.req_funct3[1:0];
                addr_q    <= bus.req_csr_addr;
                operand_q <= bus.req_funct3[2] ? {{(XLEN-5){1'b0}}, bus.req_rs1_idx}
                                               : bus.req_rs1_data;
                // set/clear with a zero source field is a pure read
                wr_en_q   <= (bus.req_funct3[1:0] == 2'b01) || (bus.req_rs1_idx != 5'd0);
                ill_q     <= 1'b0;
            end
            if ((state_q == READ) && !bus.req_kill) begin
                old_q <= illegal ? '0 : bus.csr_data_r;
                ill_q <= illegal;
            end
        end
    end

    always_comb begin
        bus.req_ready       = req_ready_int;
        bus.busy            = (state_q != IDLE);
        bus.csr_read_index  = addr_q;
        bus.csr_write_index = addr_q;
        bus.csr_write       = (state_q == WRITE) && wr_en_q;
        bus.csr_data_w      = (state_q == WRITE) ? wdata : '0;
        bus.rsp_valid       = (state_q == RESP);
        bus.rsp_rd_data     = old_q;
        bus.rsp_ill         = (state_q == RESP) && ill_q;
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a scoreboard of expected CSR writes and responses.
module tb_csr_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] csr_val = 32'h0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [31:0] rd;   logic ill;         } rsp_t;
    wr_t  wq[$];
    rsp_t rq[$];

    csr_access_unit_if #(.XLEN(32)) bus ();

    csr_access_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.csr_data_r = csr_val;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe and every response handshake must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.csr_write) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", {31'd0, bus.csr_write}, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_index",  {20'd0, bus.csr_write_index}, {20'd0, w.addr});
                    check("rd_index",  {20'd0, bus.csr_read_index},  {20'd0, w.addr});
                    check("wr_data",   bus.csr_data_w, w.data);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rsp_rd_data", bus.rsp_rd_data, r.rd);
                    check("rsp_ill",     {31'd0, bus.rsp_ill}, {31'd0, r.ill});
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csr_write"}, {31'd0, bus.csr_write}, 32'd0);
        check({tag, "_data_w"},    bus.csr_data_w, 32'd0);
        check({tag, "_rd_idx"},    {20'd0, bus.csr_read_index}, 32'd0);
        check({tag, "_wr_idx"},    {20'd0, bus.csr_write_index}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_rd"},    bus.rsp_rd_data, 32'd0);
        check({tag, "_rsp_ill"},   {31'd0, bus.rsp_ill}, 32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Entered 1ns after a rising edge with the unit idle and rsp_ready high; returns likewise.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] d, input logic [4:0] idx, input logic [31:0] old,
                          input bit exp_wr, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input bit exp_ill);
        csr_val          = old;
        bus.req_valid    = 1'b1;
        bus.req_funct3   = f3;
        bus.req_csr_addr = addr;
        bus.req_rs1_data = d;
        bus.req_rs1_idx  = idx;
        if (exp_wr) wq.push_back('{addr: addr, data: exp_wd});
        rq.push_back('{rd: exp_rd, ill: exp_ill});
        @(negedge clk);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_read_busy"},  {31'd0, bus.busy}, 32'd1);
        check({tag, "_read_nowr"},  {31'd0, bus.csr_write}, 32'd0);
        check({tag, "_read_index"}, {20'd0, bus.csr_read_index}, {20'd0, addr});
        @(posedge clk); #1;
        @(negedge clk);
        if (exp_ill) begin
            check({tag, "_ill_rsp_t2"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({tag, "_ill_nowr"},   {31'd0, bus.csr_write}, 32'd0);
        end else begin
            check({tag, "_wr_t2"},      {31'd0, bus.csr_write}, {31'd0, exp_wr});
            check({tag, "_norsp_t2"},   {31'd0, bus.rsp_valid}, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_rsp_t3"},     {31'd0, bus.rsp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_csr_addr = 12'h000;
        bus.req_rs1_data = 32'h0;
        bus.req_rs1_idx  = 5'd0;
        bus.req_kill     = 1'b0;
        bus.rsp_ready    = 1'b1;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("rw",   3'b001, 12'h340, 32'hDEADBEEF, 5'd5, 32'h12345678, 1, 32'hDEADBEEF, 32'h12345678, 0);
        run_op("rs",   3'b010, 12'h300, 32'h00000080, 5'd1, 32'h00000008, 1, 32'h00000088, 32'h00000008, 0);
        run_op("rc",   3'b011, 12'h300, 32'h00000008, 5'd1, 32'h00000088, 1, 32'h00000080, 32'h00000088, 0);
        run_op("rsi0", 3'b110, 12'h304, 32'hFFFFFFFF, 5'd0, 32'hCAFE0001, 0, 32'h0,        32'hCAFE0001, 0);
        run_op("rwi",  3'b101, 12'h305, 32'hFFFFFFFF, 5'd31, 32'h00000100, 1, 32'h0000001F, 32'h00000100, 0);
        run_op("rci",  3'b111, 12'h344, 32'h0,        5'd3, 32'h0000000F, 1, 32'h0000000C, 32'h0000000F, 0);
        run_op("ro",   3'b001, 12'hC00, 32'h11111111, 5'd4, 32'h55555555, 0, 32'h0,        32'h0,        1);
        run_op("f3_0", 3'b000, 12'h340, 32'h11111111, 5'd4, 32'h55555555, 0, 32'h0,        32'h0,        1);
        run_op("f3_4", 3'b100, 12'h341, 32'h11111111, 5'd4, 32'h55555555, 0, 32'h0,        32'h0,        1);
`ifdef CSR_ACC_ADDR_CHECK_EN
        run_op("unsup",  3'b010, 12'h7C0, 32'h00000004, 5'd2, 32'h00000077, 0, 32'h0, 32'h0, 1);
        run_op("ro_rd",  3'b010, 12'hC01, 32'h00000004, 5'd0, 32'h00000042, 0, 32'h0, 32'h0, 1);
`else
        run_op("unsup",  3'b010, 12'h7C0, 32'h00000004, 5'd2, 32'h00000077, 1, 32'h00000077, 32'h00000077, 0);
        run_op("ro_rd",  3'b010, 12'hC01, 32'h00000004, 5'd0, 32'h00000042, 0, 32'h0,        32'h00000042, 0);
`endif

        // response stall: old value held while writeback is not ready
        bus.rsp_ready    = 1'b0;
        csr_val          = 32'hAAAA5555;
        bus.req_valid    = 1'b1;
        bus.req_funct3   = 3'b001;
        bus.req_csr_addr = 12'h341;
        bus.req_rs1_data = 32'h00001111;
        bus.req_rs1_idx  = 5'd6;
        wq.push_back('{addr: 12'h341, data: 32'h00001111});
        rq.push_back('{rd: 32'hAAAA5555, ill: 1'b0});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        csr_val = 32'h0BAD0BAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_rd",    bus.rsp_rd_data, 32'hAAAA5555);
            check("stall_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_busy",  {31'd0, bus.busy}, 32'd1);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        run_op("after_stall", 3'b010, 12'h342, 32'h00000001, 5'd7, 32'h00000010, 1, 32'h00000011, 32'h00000010, 0);

        // kill while idle blocks acceptance
        bus.req_valid = 1'b1;
        bus.req_kill  = 1'b1;
        @(negedge clk);
        check("kill_idle_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_kill  = 1'b0;
        @(negedge clk);
        check("kill_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        // kill in READ: no write, no response
        bus.req_valid    = 1'b1;
        bus.req_funct3   = 3'b010;
        bus.req_csr_addr = 12'h343;
        bus.req_rs1_data = 32'h5;
        bus.req_rs1_idx  = 5'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_kill  = 1'b1;
        @(negedge clk);
        check("kill_read_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        bus.req_kill = 1'b0;
        @(negedge clk);
        check("kill_read_idle", {31'd0, bus.busy}, 32'd0);
        check("kill_read_nowr", {31'd0, bus.csr_write}, 32'd0);
        check("kill_read_norsp", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // reset during WRITE: aborts with no response
        bus.req_valid    = 1'b1;
        bus.req_funct3   = 3'b001;
        bus.req_csr_addr = 12'h342;
        bus.req_rs1_data = 32'h12121212;
        bus.req_rs1_idx  = 5'd1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_write");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("post_rst", 3'b001, 12'h340, 32'h00C0FFEE, 5'd2, 32'h00000001, 1, 32'h00C0FFEE, 32'h00000001, 0);

        check("wq_drained", wq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
